// File: rtl/output_matrix.sv
// output_matrix: projects four homogeneous points (columns of a 4x4 matrix)
// to X/W, Y/W, Z/W using a single sequential restoring divider.
// Each of the 12 divisions takes LOAD + 31 DIV + STORE = 33 cycles, so the
// latency is always 396 cycles, whatever the data.
module output_matrix #(
  parameter int FRAC = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [335:0] outMtrx,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [20:0]  po1X,
  output logic [20:0]  po1Y,
  output logic [20:0]  po1Z,
  output logic [20:0]  po2X,
  output logic [20:0]  po2Y,
  output logic [20:0]  po2Z,
  output logic [20:0]  po3X,
  output logic [20:0]  po3Y,
  output logic [20:0]  po3Z,
  output logic [20:0]  po4X,
  output logic [20:0]  po4Y,
  output logic [20:0]  po4Z,
  output logic [3:0]   div0,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int W  = 21;          // coordinate width
  localparam int DW = W + FRAC;    // dividend width = number of DIV cycles
  localparam int CW = $clog2(DW);

  localparam logic [W-1:0]  POS_SAT = 21'h0FFFFF;
  localparam logic [W-1:0]  NEG_SAT = 21'h100000;
  localparam logic [DW-1:0] POS_LIM = DW'(21'h0FFFFF);
  localparam logic [DW-1:0] NEG_LIM = DW'(21'h100000);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

  state_t         state_q, state_d;
  logic [335:0]   mtrx_q;
  logic [1:0]     pt_q;             // point index 0..3
  logic [1:0]     cp_q;             // component index 0..2 (X,Y,Z)
  logic [CW-1:0]  cnt_q;            // DIV iteration counter
  logic [DW-1:0]  dvd_q;            // dividend, shifted out MSB first
  logic [DW-1:0]  quo_q;            // quotient, shifted in LSB
  logic [W-1:0]   rem_q;            // partial remainder (always < divisor)
  logic [W-1:0]   dsr_q;            // |W|
  logic           neg_q;            // result sign
  logic [W-1:0]   po_q [12];
  logic [3:0]     div0_q;

  // Unpacked view of the stored matrix: fld[point][X,Y,Z,W].
  logic [W-1:0]   fld [4][4];
  for (genvar p = 0; p < 4; p++) begin : g_pt
    for (genvar c = 0; c < 4; c++) begin : g_cp
      assign fld[p][c] = mtrx_q[335 - 84*p - 21*c -: 21];
    end
  end

  logic [W-1:0]   num, wcur, abs_num, abs_w, diff, res;
  logic [W:0]     rem_sh;
  logic           ge, w_zero, last;
  logic [3:0]     idx;

  // Operand selection, one divider step and the signed/saturated result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    num     = fld[pt_q][cp_q];
    wcur    = fld[pt_q][3];
    abs_num = num[W-1]  ? (~num  + W'(1)) : num;
    abs_w   = wcur[W-1] ? (~wcur + W'(1)) : wcur;
    w_zero  = (wcur == '0);
    rem_sh  = {rem_q, dvd_q[DW-1]};
    ge      = (rem_sh >= {1'b0, dsr_q});
    diff    = rem_sh[W-1:0] - dsr_q;
    last    = (pt_q == 2'd3) && (cp_q == 2'd2);
    idx     = {2'b00, pt_q} * 4'd3 + {2'b00, cp_q};
    res     = '0;
    if (w_zero) begin
      if (num == '0)     res = '0;
      else if (num[W-1]) res = NEG_SAT;
      else               res = POS_SAT;
    end else if (!neg_q) begin
      res = (quo_q > POS_LIM) ? POS_SAT : quo_q[W-1:0];
    end else begin
      res = (quo_q > NEG_LIM) ? NEG_SAT : (~quo_q[W-1:0] + W'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = DIV;
      DIV:     if (cnt_q == CW'(DW - 1)) state_d = STORE;
      STORE:   state_d = last ? DONE : LOAD;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: matrix capture, divider iterations and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtrx_q <= '0;
      pt_q   <= '0;
      cp_q   <= '0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      div0_q <= '0;
      // NOTE: the result array is reset because consumers must read 0 during and after reset.
      for (int k = 0; k < 12; k++) po_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mtrx_q <= outMtrx;
            div0_q <= '0;
            pt_q   <= '0;
            cp_q   <= '0;
          end
        end
        LOAD: begin
          dvd_q <= {abs_num, {FRAC{1'b0}}};
          dsr_q <= abs_w;
          neg_q <= num[W-1] ^ wcur[W-1];
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= '0;
          if (w_zero) div0_q[pt_q] <= 1'b1;
        end
        DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (!w_zero) begin
            dvd_q <= {dvd_q[DW-2:0], 1'b0};
            rem_q <= ge ? diff : rem_sh[W-1:0];
            quo_q <= {quo_q[DW-2:0], ge};
          end
        end
        STORE: begin
          po_q[idx] <= res;
          if (cp_q == 2'd2) begin
            cp_q <= '0;
            pt_q <= pt_q + 2'd1;
          end else begin
            cp_q <= cp_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign po1X = po_q[0];
  assign po1Y = po_q[1];
  assign po1Z = po_q[2];
  assign po2X = po_q[3];
  assign po2Y = po_q[4];
  assign po2Z = po_q[5];
  assign po3X = po_q[6];
  assign po3Y = po_q[7];
  assign po3Z = po_q[8];
  assign po4X = po_q[9];
  assign po4Y = po_q[10];
  assign po4Z = po_q[11];
  assign div0 = div0_q;

endmodule
